matrix_bram_2p: RTL

Parametrised simple-dual-port matrix storage; successor to the single-port matrix BRAM. One write port and one independent read port address elements by (row, col). The block adds a transposed read mode, out-of-range rejection and a sequential zero-fill engine. It sits between the matrix loader/UART front end (write side) and the compute units (read side), so a matrix can be streamed in while a previous one is read out.

---
 rtl/matrix_bram_2p.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/matrix_bram_2p.sv
// Simple-dual-port (row, col) matrix store with transposed reads, range
// rejection and a sequential zero-fill engine that owns the write port.
module matrix_bram_2p #(
  parameter int unsigned MAX_ROWS   = 8,
  parameter int unsigned MAX_COLS   = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ROW_WIDTH  = (MAX_ROWS > 1) ? $clog2(MAX_ROWS) : 1,
  parameter int unsigned COL_WIDTH  = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1,
  parameter int unsigned DEPTH      = MAX_ROWS * MAX_COLS,
  parameter int unsigned ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ROW_WIDTH-1:0]  wr_row,
  input  logic [COL_WIDTH-1:0]  wr_col,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ROW_WIDTH-1:0]  rd_row,
  input  logic [COL_WIDTH-1:0]  rd_col,
  input  logic                  rd_transpose,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  clr_start,
  output logic                  busy,
  output logic                  clr_done,
  output logic                  wr_err
);

  localparam int unsigned IDX_WIDTH = (ROW_WIDTH > COL_WIDTH) ? ROW_WIDTH : COL_WIDTH;

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic                    busy_q, busy_d;
  logic                    clr_done_q, clr_done_d;
  logic                    wr_err_q, wr_err_d;
  logic                    rd_valid_q;
  logic [DATA_WIDTH-1:0]   rd_data_q;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    wr_ok_c;
  logic [ADDR_WIDTH-1:0]   wr_addr_c;
  logic [IDX_WIDTH-1:0]    rd_row_eff_c;
  logic [IDX_WIDTH-1:0]    rd_col_eff_c;
  logic                    rd_ok_c;
  logic [ADDR_WIDTH-1:0]   rd_addr_c;
  logic                    mem_we_c;
  logic [ADDR_WIDTH-1:0]   mem_waddr_c;
  logic [DATA_WIDTH-1:0]   mem_wdata_c;

  // Write-side decode; the address is only used when the indices are in range.
  assign wr_ok_c   = (32'(wr_row) < MAX_ROWS) && (32'(wr_col) < MAX_COLS);
  assign wr_addr_c = ADDR_WIDTH'(32'(wr_row) * MAX_COLS + 32'(wr_col));

  // Transpose swaps the roles of the indices before the range check and mapping.
  assign rd_row_eff_c = rd_transpose ? IDX_WIDTH'(rd_col) : IDX_WIDTH'(rd_row);
  assign rd_col_eff_c = rd_transpose ? IDX_WIDTH'(rd_row) : IDX_WIDTH'(rd_col);
  assign rd_ok_c      = (32'(rd_row_eff_c) < MAX_ROWS) && (32'(rd_col_eff_c) < MAX_COLS);
  assign rd_addr_c    = ADDR_WIDTH'(32'(rd_row_eff_c) * MAX_COLS + 32'(rd_col_eff_c));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      clr_done_q <= 1'b0;
      wr_err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      clr_done_q <= clr_done_d;
      wr_err_q   <= wr_err_d;
    end
  end

  // Next state and write-port arbitration: the clear owns the port while active.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    clr_done_d  = 1'b0;
    wr_err_d    = 1'b0;
    mem_we_c    = 1'b0;
    mem_waddr_c = wr_addr_c;
    mem_wdata_c = wr_data;

    case (state_q)
      ST_IDLE: begin
        if (wr_en) begin
          if (wr_ok_c) begin
            mem_we_c = 1'b1;
          end else begin
            wr_err_d = 1'b1;
          end
        end
        if (clr_start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        mem_we_c    = 1'b1;
        mem_waddr_c = cnt_q;
        mem_wdata_c = '0;
        wr_err_d    = wr_en;
        if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) begin
          state_d    = ST_IDLE;
          cnt_d      = '0;
          clr_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + ADDR_WIDTH'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d == ST_CLEAR);
  end

  // Storage array has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_q[mem_waddr_c] <= mem_wdata_c;
    end
  end

  // Registered read port; sampling before the write lands gives read-first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_en;
      if (rd_en) begin
        rd_data_q <= rd_ok_c ? mem_q[rd_addr_c] : '0;
      end
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;
  assign clr_done = clr_done_q;
  assign wr_err   = wr_err_q;

endmodule
